button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Multi-channel front end for the board push-buttons (reset, up1, down1, up2, down2).
//   Per channel: 2-FF synchronizer, counter debounce, press/release edge pulses and a
//   hold-to-repeat strobe for paddle motion. Sits directly upstream of the top-level game
//   logic; its outputs drive pixel_gen paddle control and the game reset path.
// PARAMETERS
//   N_BTN          5           number of independent button channels
//   DEBOUNCE_CYCLES 1_000_000  consecutive stable clocks before level changes (10 ms @100 MHz), >=1
//   REPEAT_DELAY   50_000_000  clocks from press to first auto-repeat strobe (500 ms); 0 = repeat off
//   REPEAT_PERIOD  10_000_000  clocks between later auto-repeat strobes (100 ms), >=1
// PORTS
//   clk       in   1      system clock, 100 MHz
//   reset     in   1      synchronous, active-high reset
//   btn_in    in   N_BTN  raw asynchronous button inputs, active-high
//   level     out  N_BTN  debounced button level
//   press     out  N_BTN  1-cycle pulse on debounced 0->1
//   release   out  N_BTN  1-cycle pulse on debounced 1->0
//   strobe    out  N_BTN  1-cycle pulse: at press, then auto-repeat while held
// BEHAVIOUR
//   - One clock, one synchronous active-high reset. All outputs registered.
//   - Reset: level, press, release, strobe = 0; sync FFs, debounce and repeat counters = 0.
//     Reset mid-debounce or mid-hold discards progress; a button held through reset
//     produces a fresh press after the normal latency once reset drops.
//   - Sync: s1 <= btn_in; s2 <= s1. Only s2 is used downstream.
//   - Debounce (per channel): if s2 == level, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1:
//     level <= s2, cnt <= 0; else cnt <= cnt+1. Any bounce back to level restarts the count.
//   - Latency: btn_in sampled at edge k -> level updates at edge k+1+DEBOUNCE_CYCLES.
//     Pulses shorter than DEBOUNCE_CYCLES clocks at s2 never change level.
//   - press/release are asserted in the same cycle that level changes, for exactly 1 cycle.
//   - Repeat counter rc (per channel): cleared on press and while level=0; increments while held.
//     strobe asserted at press edge p, then at p+REPEAT_DELAY, then every REPEAT_PERIOD
//     clocks after that, until release. Release cycle never carries a strobe. REPEAT_DELAY=0 ->
//     strobe == press.
//   - Counter widths: $clog2(max+1) of the respective parameter; no wrap is reachable in
//     normal operation. rc saturates in the post-delay phase by reloading at each repeat.
//   - Channels fully independent; simultaneous events on several channels all reported in the
//     same cycle. press and release are never high together on one channel.
// TESTING  (bench params: N_BTN=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//   1 btn_in[0] 0->1 sampled at edge 10, held -> level[0]=1 from edge 15; press[0], strobe[0]
//     high only in cycle after edge 15; release=0.
//   2 btn_in[1] high for 3 cycles then low -> level[1], press, release, strobe stay 0.
//   3 btn_in[2] held from edge 10 -> strobe[2] at edges 15, 23, 26, 29, ...; release at
//     btn_in low at edge 40 -> level[2]=0 at edge 45, release[2] 1 cycle, no strobe after.
//   4 btn_in[3] released with bounce 0,1,0 (2 cycles each) then stable 0 -> exactly one
//     release[3], 4+1 cycles after the final 1->0 sample; no extra press.
//   5 reset high at edge 20 while btn_in[0] held -> all outputs 0 at edge 21; reset low at
//     edge 25 -> press[0] at edge 30.
//   6 btn_in[0] and btn_in[4] rise at same edge -> press[0], press[4] in same cycle; others 0.

Source files
------------

// File: rtl/button_conditioner.sv
// Per-channel push-button front end: 2-FF sync, counter debounce, press/release
// pulses and a hold-to-repeat strobe. All outputs registered.
`timescale 1ns/1ps
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_BTN-1:0] btn_in_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] strobe_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned PW = $clog2(REPEAT_PERIOD + 1);
  localparam int unsigned RW = (DW > PW) ? DW : PW;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] strobe_q, strobe_d;
  logic [N_BTN-1:0] rep_phase_q, rep_phase_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [RW-1:0]    rc_q  [N_BTN];
  logic [RW-1:0]    rc_d  [N_BTN];

  always_comb begin
    level_d     = level_q;
    press_d     = '0;
    release_d   = '0;
    strobe_d    = '0;
    rep_phase_d = rep_phase_q;
    cnt_d       = cnt_q;
    rc_d        = rc_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      // rc counts toward REPEAT_DELAY first, then is reloaded each REPEAT_PERIOD.
      if (!(level_q[i] && level_d[i])) begin
        rc_d[i]        = '0;
        rep_phase_d[i] = 1'b0;
        strobe_d[i]    = press_d[i];
      end else if (REPEAT_DELAY == 0) begin
        rc_d[i] = '0;
      end else if (rc_q[i] == (rep_phase_q[i] ? RP_LAST : RD_LAST)) begin
        strobe_d[i]    = 1'b1;
        rc_d[i]        = '0;
        rep_phase_d[i] = 1'b1;
      end else begin
        rc_d[i] = rc_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      strobe_q    <= '0;
      rep_phase_q <= '0;
      cnt_q       <= '{default: '0};
      rc_q        <= '{default: '0};
    end else begin
      s1_q        <= btn_in_i;
      s2_q        <= s1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      strobe_q    <= strobe_d;
      rep_phase_q <= rep_phase_d;
      cnt_q       <= cnt_d;
      rc_q        <= rc_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign strobe_o  = strobe_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: behavioural window/timestamp model checked every
// cycle, directed literal scenarios, then randomized bouncy stimulus with resets.
`timescale 1ns/1ps
module tb_button_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] level, press, rel, strobe;

  button_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .btn_in_i(btn),
    .level_o(level),
    .press_o(press),
    .release_o(rel),
    .strobe_o(strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int base   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  // Model: history of raw samples per channel; level flips once the DB samples
  // seen at s2 all disagree with it; strobes from time elapsed since the press.
  bit [31:0]    hist [N];
  logic [N-1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_strobe = '0;
  int           press_at [N];

  always @(posedge clk) begin
    logic [N-1:0] old_lvl;
    edge_n++;
    old_lvl = m_lvl;
    m_press = '0; m_rel = '0; m_strobe = '0;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        hist[c] = '0;
        press_at[c] = 0;
      end
      m_lvl = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        bit flip;
        flip = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (hist[c][j] == old_lvl[c]) flip = 1'b0;
        if (flip) begin
          m_lvl[c] = ~old_lvl[c];
          m_press[c] = m_lvl[c];
          m_rel[c] = ~m_lvl[c];
        end
        if (m_press[c]) begin
          press_at[c] = edge_n;
          m_strobe[c] = 1'b1;
        end else if (old_lvl[c] && m_lvl[c] && RD > 0) begin
          int k;
          k = edge_n - press_at[c];
          m_strobe[c] = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
        end
        hist[c] = {hist[c][30:0], btn[c]};
      end
    end
    #1;
    check("model_level", level, m_lvl);
    check("model_press", press, m_press);
    check("model_release", rel, m_rel);
    check("model_strobe", strobe, m_strobe);
    if ((press & rel) != '0) check("press_and_release", press & rel, '0);
  end

  task automatic go_to(input int k);
    while (edge_n < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    btn = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    base = edge_n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int hold [N];

    // Channels 0,2,4 held from edge 10; channel 1 a 3-cycle glitch.
    reset_seq();
    go_to(9);  btn = 5'b10111;
    go_to(12); btn[1] = 1'b0;
    go_to(14); check("A_level_e14", level, 5'b00000);
    go_to(15);
    check("A_level_e15", level, 5'b10101);
    check("A_press_e15", press, 5'b10101);
    check("A_strobe_e15", strobe, 5'b10101);
    check("A_release_e15", rel, 5'b00000);
    go_to(16);
    check("A_press_e16", press, 5'b00000);
    check("A_strobe_e16", strobe, 5'b00000);
    go_to(20); check("A_level_e20", level, 5'b10101);
    go_to(23); check("A_strobe_e23", strobe, 5'b10101);
    go_to(24); check("A_strobe_e24", strobe, 5'b00000);
    go_to(26); check("A_strobe_e26", strobe, 5'b10101);
    go_to(39); btn[2] = 1'b0;
    go_to(44); check("A_strobe_e44", strobe, 5'b10101);
    go_to(45);
    check("A_level_e45", level, 5'b10001);
    check("A_release_e45", rel, 5'b00100);
    check("A_strobe_e45", strobe, 5'b00000);
    go_to(46); check("A_release_e46", rel, 5'b00000);

    // Channel 3 release with bounce.
    reset_seq();
    btn[3] = 1'b1;
    go_to(19); btn[3] = 1'b0;
    go_to(21); btn[3] = 1'b1;
    go_to(23); btn[3] = 1'b0;
    go_to(28);
    check("B_level_e28", level, 5'b01000);
    check("B_release_e28", rel, 5'b00000);
    go_to(29);
    check("B_release_e29", rel, 5'b01000);
    check("B_level_e29", level, 5'b00000);
    check("B_press_e29", press, 5'b00000);
    go_to(30); check("B_release_e30", rel, 5'b00000);

    // Reset while channel 0 held.
    reset_seq();
    btn[0] = 1'b1;
    go_to(19); rst = 1'b1;
    go_to(21);
    check("C_level_e21", level, 5'b00000);
    check("C_press_e21", press, 5'b00000);
    check("C_strobe_e21", strobe, 5'b00000);
    go_to(24); rst = 1'b0;
    go_to(29); check("C_level_e29", level, 5'b00000);
    go_to(30);
    check("C_press_e30", press, 5'b00001);
    check("C_strobe_e30", strobe, 5'b00001);
    check("C_level_e30", level, 5'b00001);

    // Random holds: short bounces, marginal, and long holds; rare resets.
    reset_seq();
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          int r;
          r = $urandom_range(0, 2);
          btn[c] = ~btn[c];
          hold[c] = (r == 0) ? $urandom_range(1, 3) :
                    (r == 1) ? $urandom_range(4, 7) : $urandom_range(20, 45);
        end else begin
          hold[c]--;
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
